// File: rtl/pre_if_stage.sv
// Pre-fetch stage: owns the fetch PC, drives the instruction-SRAM address
// handshake and hands each issued (or address-faulting) fetch to the fetch stage.
module pre_if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h1c000000,
   parameter int          BR_BUS_WD = 33
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [BR_BUS_WD-1:0] br_bus,
   input  logic                 flush_valid,
   input  logic [31:0]          flush_target,
   input  logic                 fs_allowin,
   output logic                 ps_to_fs_valid,
   output logic [33:0]          ps_to_fs_bus,
   output logic                 inst_sram_req,
   output logic                 inst_sram_wr,
   output logic [1:0]           inst_sram_size,
   output logic [31:0]          inst_sram_addr,
   input  logic                 inst_sram_addr_ok
);

   // state  | meaning
   // S_REQ  | presenting ps_pc to the SRAM (or offering an adef entry)
   // S_HOLD | address accepted, entry waiting for fs_allowin
   // S_HALT | adef entry handed off, only a flush restarts fetch
   typedef enum logic [1:0] {S_REQ, S_HOLD, S_HALT} state_e;

   state_e      state_q, state_d;
   logic [31:0] ps_pc_q, ps_pc_d;
   logic        rd_valid_q, rd_valid_d;
   logic [31:0] rd_target_q, rd_target_d;
   logic        cancel_q, cancel_d;
   logic [31:0] held_pc_q, held_pc_d;

   logic        br_taken;
   logic [31:0] br_target;
   logic        redirect;
   logic [31:0] redir_target;
   logic        adef;
   logic        cancel_now;
   logic [31:0] next_pc;

   assign br_taken     = br_bus[BR_BUS_WD-1];
   assign br_target    = br_bus[31:0];
   assign redirect     = flush_valid | br_taken;
   assign redir_target = flush_valid ? flush_target : br_target;
   assign adef         = (ps_pc_q[1:0] != 2'b00);
   assign cancel_now   = rd_valid_q | redirect;
   assign next_pc      = redirect ? redir_target : (rd_valid_q ? rd_target_q : ps_pc_q + 32'd4);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_REQ;
         ps_pc_q     <= RESET_PC;
         rd_valid_q  <= 1'b0;
         rd_target_q <= 32'h0;
         cancel_q    <= 1'b0;
         held_pc_q   <= 32'h0;
      end else begin
         state_q     <= state_d;
         ps_pc_q     <= ps_pc_d;
         rd_valid_q  <= rd_valid_d;
         rd_target_q <= rd_target_d;
         cancel_q    <= cancel_d;
         held_pc_q   <= held_pc_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ps_pc_d     = ps_pc_q;
      rd_valid_d  = rd_valid_q;
      rd_target_d = rd_target_q;
      cancel_d    = cancel_q;
      held_pc_d   = held_pc_q;
      case (state_q)
         S_REQ: begin
            if (adef) begin
               if (flush_valid) ps_pc_d = flush_target;
               else if (fs_allowin) state_d = S_HALT;
            end else if (inst_sram_addr_ok) begin
               cancel_d   = cancel_now;
               rd_valid_d = 1'b0;
               if (fs_allowin) begin
                  ps_pc_d = next_pc;
               end else begin
                  // park the follow-on PC in the redirect slot until fetch drains
                  state_d     = S_HOLD;
                  rd_target_d = next_pc;
                  rd_valid_d  = 1'b1;
                  held_pc_d   = ps_pc_q;
               end
            end else if (redirect) begin
               rd_valid_d  = 1'b1;
               rd_target_d = redir_target;
            end
         end
         S_HOLD: begin
            if (fs_allowin) begin
               ps_pc_d    = redirect ? redir_target : rd_target_q;
               rd_valid_d = 1'b0;
               cancel_d   = 1'b0;
               state_d    = S_REQ;
            end else if (redirect) begin
               cancel_d    = 1'b1;
               rd_target_d = redir_target;
            end
         end
         S_HALT: begin
            if (flush_valid) begin
               ps_pc_d    = flush_target;
               rd_valid_d = 1'b0;
               cancel_d   = 1'b0;
               state_d    = S_REQ;
            end
         end
         default: state_d = S_REQ;
      endcase
   end

   always_comb begin
      inst_sram_req  = 1'b0;
      ps_to_fs_valid = 1'b0;
      ps_to_fs_bus   = 34'h0;
      if (!reset) begin
         case (state_q)
            S_REQ: begin
               inst_sram_req = ~adef;
               if (adef) begin
                  ps_to_fs_valid = 1'b1;
                  ps_to_fs_bus   = {1'b0, 1'b1, ps_pc_q};
               end else if (inst_sram_addr_ok) begin
                  ps_to_fs_valid = 1'b1;
                  ps_to_fs_bus   = {cancel_now, 1'b0, ps_pc_q};
               end
            end
            S_HOLD: begin
               // a redirect arriving in the hand-off cycle still kills the held entry
               ps_to_fs_valid = 1'b1;
               ps_to_fs_bus   = {cancel_q | redirect, 1'b0, held_pc_q};
            end
            default: ;
         endcase
      end
   end

   assign inst_sram_wr   = 1'b0;
   assign inst_sram_size = 2'b10;
   assign inst_sram_addr = ps_pc_q;

endmodule

// File: doc/pre_if_stage.md
Name: pre_if_stage

Overview:
- Pre-fetch (PS) stage, directly upstream of the fetch stage.
- Owns the architectural fetch PC and issues instruction-SRAM address requests using a req/addr_ok handshake.
- Hands each accepted (or address-faulting) fetch to the fetch stage as {cancel, adef, pc}.
- Absorbs branch and exception/ertn redirects at any point of the request handshake without ever changing an address that is already being presented.

Parameters:
- RESET_PC, 32'h1c000000, first fetch address after reset.
- BR_BUS_WD, 33, branch bus width: {br_taken[32], br_target[31:0]}.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- br_bus  input  BR_BUS_WD  branch redirect from decode: {br_taken, br_target}.
- flush_valid  input  1  exception/ertn redirect from writeback; single-cycle pulse.
- flush_target  input  32  ex_entry or era, already selected by writeback.
- fs_allowin  input  1  fetch stage can accept a new entry this cycle.
- ps_to_fs_valid  output  1  the PS entry is handed to fetch this cycle when fs_allowin=1.
- ps_to_fs_bus  output  34  {cancel[33], adef[32], pc[31:0]}.
- inst_sram_req  output  1  address request.
- inst_sram_wr  output  1  constant 0.
- inst_sram_size  output  2  constant 2'b10 (word).
- inst_sram_addr  output  32  request address.
- inst_sram_addr_ok  input  1  address accepted this cycle.

Behaviour:
- Reset (async): state=REQ, ps_pc=RESET_PC, rd_valid=0, rd_target=0, cancel_r=0.
  - Outputs during reset: req=0, ps_to_fs_valid=0, bus=0.
- Redirect source this cycle: flush_valid has priority over br_taken. Target = flush_target if flush_valid, else br_target.
- States:
  - REQ: issuing ps_pc.
  - HOLD: address accepted, waiting fs_allowin.
  - HALT: adef entry handed off, waiting for a flush.
- Address error: adef = (ps_pc[1:0] != 0).
- REQ:
  - inst_sram_req = ~adef; inst_sram_addr = ps_pc. Address stays stable while req=1 and addr_ok=0.
  - Handshake happens when req & addr_ok.
  - A redirect while req=1 with no handshake sets rd_valid=1, rd_target=target. A later redirect overwrites it; flush always overwrites.
  - On handshake, cancel_r = rd_valid | redirect-this-cycle. Next PC priority: redirect this cycle, else rd_target if rd_valid, else ps_pc+4. rd_valid is cleared.
  - If fs_allowin=1 in the handshake cycle: ps_to_fs_valid=1, bus={cancel, 0, ps_pc}, ps_pc <= next PC, stay in REQ (zero-bubble back-to-back issue).
  - Otherwise go to HOLD, latching next PC into rd_target with rd_valid=1 and the handed entry's pc into held_pc.
  - adef=1 in REQ: no sram request; ps_to_fs_valid=1 with bus={0,1,ps_pc}.
    - With a flush this cycle: ps_pc <= flush_target and stay in REQ; the entry is still offered.
    - Otherwise, when fs_allowin=1, go to HALT.
- HOLD:
  - req=0; ps_to_fs_valid=1; bus={cancel_r, 0, held_pc}.
  - A redirect in HOLD sets cancel_r=1 and rd_target=target.
  - When fs_allowin=1: ps_pc <= rd_target (or the redirect target if one arrives this cycle), rd_valid=0, cancel_r=0, go to REQ.
- HALT:
  - req=0, ps_to_fs_valid=0; br_taken is ignored.
  - flush_valid: ps_pc <= flush_target, go to REQ.
- Cancelled entries (cancel=1) still consume one fetch slot; fetch discards the returned data.
- Redirects are never lost: exactly one cancelled stale entry per in-flight address, and the next issued address equals the latest redirect target.
- PC arithmetic is modulo 2^32 (0xfffffffc + 4 = 0).
- Reset mid-handshake: all state returns to reset values immediately (async), and req drops the same cycle.

Test Plan:
- Reset release, addr_ok=1, fs_allowin=1 -> addresses 0x1c000000, 0x1c000004, 0x1c000008 on consecutive cycles, all with cancel=0.
- addr_ok held 0 for 3 cycles, with br_taken=1, target 0x1c000100 at cycle 1 -> addr stays 0x1c000000 until addr_ok; that entry has cancel=1; next address is 0x1c000100.
- Handshake with fs_allowin=0 for 2 cycles -> HOLD, req=0, bus pc stable. Branch during HOLD to 0x1c000200 -> entry handed with cancel=1, next request is 0x1c000200.
- Same cycle br_taken (0x1c000300) and flush_valid (0x1c008000) -> next address 0x1c008000.
- flush_target=0x1c000002 -> no req; entry {0,1,0x1c000002} offered; HALT; req stays 0 despite br_taken. Flush to 0x1c000010 -> fetch resumes at 0x1c000010.
- Assert reset while req=1 and addr_ok=0 -> req=0 in the same cycle; after release the first address is 0x1c000000.
